// File: rtl/cp0_intr_ctrl.sv
// Coprocessor-0 interrupt/exception controller: Status/Cause/EPC/Count/Compare,
// synchronised level/edge IRQ lines, Count/Compare timer and PC redirect select.
module cp0_intr_ctrl #(
  parameter int                 NUM_IRQ    = 4,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE   = '0,
  parameter bit                 TIMER_EN   = 1'b1,
  parameter logic [31:0]        EXC_VECTOR = 32'h0000_0008
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               inst_valid,
  input  logic [31:0]        pc,
  input  logic               exc_sys,
  input  logic               exc_uni,
  input  logic               exc_ovr,
  input  logic               mtc0,
  input  logic               mfc0,
  input  logic               eret,
  input  logic [4:0]         rd,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               exc_req,
  output logic [1:0]         selpc,
  output logic [31:0]        epc_out,
  output logic [NUM_IRQ:0]   irq_ack
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_UNI = 5'd10;
  localparam logic [4:0] EXC_OVR = 5'd12;

  generate
    if (NUM_IRQ < 1 || NUM_IRQ > 7) begin : g_bad_num_irq
      $error("cp0_intr_ctrl: NUM_IRQ must be in 1..7");
    end
    if (EXC_VECTOR[1:0] != 2'b00) begin : g_bad_vector
      $error("cp0_intr_ctrl: EXC_VECTOR must be word aligned");
    end
  endgenerate

  // One-hot of the highest-indexed request; the timer sits at the top index.
  function automatic logic [NUM_IRQ:0] pick_highest(input logic [NUM_IRQ:0] req);
    logic [NUM_IRQ:0] g;
    g = '0;
    for (int i = 0; i <= NUM_IRQ; i++) begin
      if (req[i]) begin
        g    = '0;
        g[i] = 1'b1;
      end else begin
        g = g;
      end
    end
    return g;
  endfunction

  logic [NUM_IRQ-1:0] s1_r, s2_r, s3_r, pend_r;
  logic               tmr_pend_r;
  logic [31:0]        count_r, compare_r, epc_r;
  logic               ie_r, se_r, ue_r, oe_r, exl_r;
  logic [NUM_IRQ:0]   im_r;
  logic [4:0]         exccode_r;

  logic [NUM_IRQ:0]   ip_s, src_ack_s, irq_ack_s;
  logic               int_take_s, exc_req_s, wr_s, eret_s;
  logic [4:0]         code_s;
  logic [31:0]        epc_next_s, status_s, cause_s, rdata_s;

  assign ip_s = {tmr_pend_r, (IRQ_EDGE & pend_r) | (~IRQ_EDGE & s2_r)};

  // Take decision, source priority and exception bookkeeping values.
  always_comb begin
    int_take_s = ie_r & (|(ip_s & im_r));
    exc_req_s  = inst_valid & ~exl_r &
                 (int_take_s | (exc_ovr & oe_r) | (exc_uni & ue_r) | (exc_sys & se_r));
    src_ack_s  = '0;
    code_s     = EXC_INT;
    epc_next_s = pc;
    if (int_take_s) begin
      src_ack_s = pick_highest(ip_s & im_r);
      code_s    = EXC_INT;
    end else if (exc_ovr & oe_r) begin
      code_s = EXC_OVR;
    end else if (exc_uni & ue_r) begin
      code_s = EXC_UNI;
    end else if (exc_sys & se_r) begin
      code_s     = EXC_SYS;
      epc_next_s = pc + 32'd4;
    end else begin
      code_s = EXC_INT;
    end
    irq_ack_s = exc_req_s ? src_ack_s : '0;
    wr_s      = mtc0 & ~exc_req_s;
    eret_s    = eret & ~exc_req_s;
  end

  // Register read view and mfc0 data mux.
  always_comb begin
    status_s                = 32'd0;
    status_s[8+NUM_IRQ:8]   = im_r;
    status_s[4:0]           = {exl_r, oe_r, ue_r, se_r, ie_r};
    cause_s                 = 32'd0;
    cause_s[8+NUM_IRQ:8]    = ip_s;
    cause_s[6:2]            = exccode_r;
    rdata_s                 = 32'd0;
    if (mfc0) begin
      case (rd)
        REG_COUNT:   rdata_s = TIMER_EN ? count_r : 32'd0;
        REG_COMPARE: rdata_s = TIMER_EN ? compare_r : 32'd0;
        REG_STATUS:  rdata_s = status_s;
        REG_CAUSE:   rdata_s = cause_s;
        REG_EPC:     rdata_s = epc_r;
        default:     rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign rdata   = rdata_s;
  assign exc_req = exc_req_s;
  assign irq_ack = irq_ack_s;
  assign selpc   = exc_req_s ? 2'b10 : (eret_s ? 2'b01 : 2'b00);
  assign epc_out = epc_r;

  // IRQ synchronisers and sticky edge-pending flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r   <= '0;
      s2_r   <= '0;
      s3_r   <= '0;
      pend_r <= '0;
    end else begin
      s1_r   <= irq;
      s2_r   <= s1_r;
      s3_r   <= s2_r;
      pend_r <= (pend_r & ~irq_ack_s[NUM_IRQ-1:0]) | (IRQ_EDGE & s2_r & ~s3_r);
    end
  end

  // Count/Compare timer; a Compare write drops any latched timer request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r    <= 32'd0;
      compare_r  <= 32'hFFFF_FFFF;
      tmr_pend_r <= 1'b0;
    end else if (TIMER_EN) begin
      count_r <= (wr_s && rd == REG_COUNT) ? wdata : count_r + 32'd1;
      if (wr_s && rd == REG_COMPARE) begin
        compare_r  <= wdata;
        tmr_pend_r <= 1'b0;
      end else if (count_r == compare_r) begin
        tmr_pend_r <= 1'b1;
      end else if (irq_ack_s[NUM_IRQ]) begin
        tmr_pend_r <= 1'b0;
      end
    end
  end

  // Status/Cause/EPC: exception entry, eret and mtc0 writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_r      <= 1'b0;
      se_r      <= 1'b0;
      ue_r      <= 1'b0;
      oe_r      <= 1'b0;
      exl_r     <= 1'b0;
      im_r      <= '0;
      exccode_r <= 5'd0;
      epc_r     <= 32'd0;
    end else if (exc_req_s) begin
      exl_r     <= 1'b1;
      exccode_r <= code_s;
      epc_r     <= epc_next_s;
    end else begin
      if (eret_s) begin
        exl_r <= 1'b0;
      end
      if (wr_s) begin
        case (rd)
          REG_STATUS: begin
            ie_r  <= wdata[0];
            se_r  <= wdata[1];
            ue_r  <= wdata[2];
            oe_r  <= wdata[3];
            exl_r <= wdata[4];
            im_r  <= wdata[8+NUM_IRQ:8];
          end
          REG_CAUSE: exccode_r <= wdata[6:2];
          REG_EPC:   epc_r     <= wdata;
          default:   epc_r     <= epc_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// Directed self-checking bench for cp0_intr_ctrl (4 IRQs, line 2 edge-triggered, timer on).
module tb_cp0_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic        inst_valid;
  logic [31:0] pc;
  logic        exc_sys, exc_uni, exc_ovr;
  logic        mtc0, mfc0, eret;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        exc_req;
  logic [1:0]  selpc;
  logic [31:0] epc_out;
  logic [4:0]  irq_ack;

  int total = 0;
  int bad   = 0;

  cp0_intr_ctrl #(
    .NUM_IRQ(4), .IRQ_EDGE(4'b0100), .TIMER_EN(1'b1), .EXC_VECTOR(32'h0000_0008)
  ) dut (
    .clk(clk), .rst(rst), .irq(irq), .inst_valid(inst_valid), .pc(pc),
    .exc_sys(exc_sys), .exc_uni(exc_uni), .exc_ovr(exc_ovr),
    .mtc0(mtc0), .mfc0(mfc0), .eret(eret), .rd(rd), .wdata(wdata),
    .rdata(rdata), .exc_req(exc_req), .selpc(selpc), .epc_out(epc_out),
    .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    mtc0 = 1'b1; rd = r; wdata = d;
    cyc();
    mtc0 = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    logic [31:0] v;
    rd = r; mfc0 = 1'b1;
    #1;
    v = rdata;
    mfc0 = 1'b0;
    chk(tag, v, exp);
  endtask

  task automatic chk_out(input string tag, input logic e_req, input logic [1:0] e_sel,
                         input logic [4:0] e_ack);
    #1;
    chk({tag, ".exc_req"}, {31'd0, exc_req}, {31'd0, e_req});
    chk({tag, ".selpc"},   {30'd0, selpc},   {30'd0, e_sel});
    chk({tag, ".irq_ack"}, {27'd0, irq_ack}, {27'd0, e_ack});
  endtask

  initial begin
    rst = 1'b1; irq = 4'hF; inst_valid = 1'b0; pc = 32'd0;
    exc_sys = 1'b0; exc_uni = 1'b0; exc_ovr = 1'b0;
    mtc0 = 1'b0; mfc0 = 1'b0; eret = 1'b0; rd = 5'd0; wdata = 32'd0;

    // Reset with all irq lines high
    cyc(); cyc();
    chk_out("rst", 1'b0, 2'b00, 5'b00000);
    chk("rst.rdata", rdata, 32'd0);
    chk_reg("rst.compare", 5'd11, 32'hFFFF_FFFF);
    chk_reg("rst.status", 5'd12, 32'd0);
    chk_reg("rst.cause", 5'd13, 32'd0);
    irq = 4'h0;
    cyc();
    rst = 1'b0;
    cyc(); cyc(); cyc();
    chk_reg("rst.epc", 5'd14, 32'd0);

    // Level line 0
    wr(5'd12, 32'h0000_0101);
    pc = 32'h40; inst_valid = 1'b1; irq[0] = 1'b1;
    chk_out("lvl.t0", 1'b0, 2'b00, 5'b00000);
    cyc();
    chk_out("lvl.t1", 1'b0, 2'b00, 5'b00000);
    cyc();
    chk_out("lvl.t2", 1'b1, 2'b10, 5'b00001);
    chk_reg("lvl.cause_pre", 5'd13, 32'h0000_0100);
    cyc();
    inst_valid = 1'b0;
    chk_reg("lvl.epc", 5'd14, 32'h40);
    chk_reg("lvl.status", 5'd12, 32'h0000_0111);
    chk_reg("lvl.cause", 5'd13, 32'h0000_0100);
    irq[0] = 1'b0;
    cyc(); cyc(); cyc();
    eret = 1'b1;
    chk_out("lvl.eret", 1'b0, 2'b01, 5'b00000);
    cyc();
    eret = 1'b0;
    chk_reg("lvl.status_eret", 5'd12, 32'h0000_0101);

    // Edge line 2: pulse held until IE set
    wr(5'd12, 32'h0000_0400);
    irq[2] = 1'b1;
    cyc();
    irq[2] = 1'b0;
    for (int k = 0; k < 10; k++) cyc();
    chk_reg("edge.cause_pend", 5'd13, 32'h0000_0400);
    wr(5'd12, 32'h0000_0401);
    pc = 32'h200; inst_valid = 1'b1;
    chk_out("edge.take", 1'b1, 2'b10, 5'b00100);
    cyc();
    inst_valid = 1'b0;
    chk_reg("edge.cause_clr", 5'd13, 32'h0000_0000);
    chk_reg("edge.epc", 5'd14, 32'h200);
    chk_reg("edge.status", 5'd12, 32'h0000_0411);
    eret = 1'b1;
    chk_out("edge.eret", 1'b0, 2'b01, 5'b00000);
    chk("edge.epc_out", epc_out, 32'h200);
    cyc();
    eret = 1'b0;
    chk_reg("edge.status_eret", 5'd12, 32'h0000_0401);
    inst_valid = 1'b1;
    chk_out("edge.once", 1'b0, 2'b00, 5'b00000);
    inst_valid = 1'b0;

    // Timer: Compare=5, Count=0
    wr(5'd12, 32'h0000_1001);
    wr(5'd11, 32'd5);
    wr(5'd9, 32'd0);
    chk_reg("tmr.count0", 5'd9, 32'd0);
    pc = 32'h300; inst_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk_out("tmr.wait", 1'b0, 2'b00, 5'b00000);
    end
    chk_reg("tmr.count5", 5'd9, 32'd5);
    cyc();
    chk_out("tmr.take", 1'b1, 2'b10, 5'b10000);
    cyc();
    inst_valid = 1'b0;
    chk_reg("tmr.cause_ack", 5'd13, 32'h0000_0000);
    chk_reg("tmr.epc", 5'd14, 32'h300);
    wr(5'd12, 32'h0000_1000);
    wr(5'd11, 32'h12);
    wr(5'd9, 32'h10);
    cyc(); cyc(); cyc();
    chk_reg("tmr.cause_set", 5'd13, 32'h0000_1000);
    wr(5'd11, 32'h0);
    chk_reg("tmr.cause_cmpclr", 5'd13, 32'h0000_0000);

    // Syscall vs pending line 1
    wr(5'd12, 32'h0000_0203);
    irq[1] = 1'b1;
    cyc(); cyc();
    pc = 32'h100; inst_valid = 1'b1; exc_sys = 1'b1;
    chk_out("sys.intwin", 1'b1, 2'b10, 5'b00010);
    cyc();
    inst_valid = 1'b0; exc_sys = 1'b0; irq[1] = 1'b0;
    chk_reg("sys.cause_int", 5'd13, 32'h0000_0200);
    chk_reg("sys.epc_int", 5'd14, 32'h100);
    cyc(); cyc(); cyc();
    eret = 1'b1;
    cyc();
    eret = 1'b0;
    chk_reg("sys.status_eret", 5'd12, 32'h0000_0203);
    inst_valid = 1'b1; exc_sys = 1'b1;
    chk_out("sys.take", 1'b1, 2'b10, 5'b00000);
    cyc();
    inst_valid = 1'b0; exc_sys = 1'b0;
    chk_reg("sys.cause", 5'd13, 32'h0000_0020);
    chk_reg("sys.epc", 5'd14, 32'h104);
    chk_reg("sys.status", 5'd12, 32'h0000_0213);

    // EXL blocks; Cause write only ExcCode; unmapped rd
    wr(5'd12, 32'h0000_0119);
    irq[0] = 1'b1;
    cyc(); cyc();
    inst_valid = 1'b1; exc_ovr = 1'b1; pc = 32'h400;
    chk_out("exl.block", 1'b0, 2'b00, 5'b00000);
    wr(5'd13, 32'hFFFF_FFFF);
    chk_reg("exl.cause_wr", 5'd13, 32'h0000_017C);
    wr(5'd7, 32'hFFFF_FFFF);
    chk_reg("exl.rd7", 5'd7, 32'd0);
    chk_reg("exl.epc", 5'd14, 32'h104);
    chk_reg("exl.status", 5'd12, 32'h0000_0119);
    wr(5'd12, 32'h0000_0109);
    chk_out("exl.released", 1'b1, 2'b10, 5'b00001);
    cyc();
    inst_valid = 1'b0; exc_ovr = 1'b0; irq[0] = 1'b0;
    chk_reg("exl.cause_int", 5'd13, 32'h0000_0100);
    chk_reg("exl.epc_int", 5'd14, 32'h400);
    cyc(); cyc(); cyc();

    // Overflow and unimplemented alone
    wr(5'd12, 32'h0000_0008);
    pc = 32'h500; inst_valid = 1'b1; exc_ovr = 1'b1;
    chk_out("ovr.take", 1'b1, 2'b10, 5'b00000);
    cyc();
    inst_valid = 1'b0; exc_ovr = 1'b0;
    chk_reg("ovr.cause", 5'd13, 32'h0000_0030);
    chk_reg("ovr.epc", 5'd14, 32'h500);
    wr(5'd12, 32'h0000_0004);
    pc = 32'h600; inst_valid = 1'b1; exc_uni = 1'b1;
    chk_out("uni.take", 1'b1, 2'b10, 5'b00000);
    cyc();
    inst_valid = 1'b0; exc_uni = 1'b0;
    chk_reg("uni.cause", 5'd13, 32'h0000_0028);
    chk_reg("uni.epc", 5'd14, 32'h600);

    // Reset mid-operation drops pending edge request
    irq[2] = 1'b1;
    cyc();
    irq[2] = 1'b0;
    cyc(); cyc(); cyc();
    chk_reg("mrst.cause_pre", 5'd13, 32'h0000_0428);
    rst = 1'b1;
    chk_reg("mrst.cause", 5'd13, 32'h0000_0000);
    chk_reg("mrst.status", 5'd12, 32'h0000_0000);
    cyc();
    rst = 1'b0;
    cyc();
    chk_reg("mrst.compare", 5'd11, 32'hFFFF_FFFF);
    chk_reg("mrst.cause_post", 5'd13, 32'h0000_0000);
    rd = 5'd12; mfc0 = 1'b0;
    #1;
    chk("mrst.rdata_idle", rdata, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_intr_ctrl.md
Name: cp0_intr_ctrl

Overview:
Parametrised coprocessor-0 interrupt/exception controller for the single-cycle MIPS CPU. It holds the Status, Cause, EPC, Count and Compare registers, and synchronises NUM_IRQ external interrupt lines, each configurable as level- or edge-triggered. It adds an internal Count/Compare timer interrupt and an EXL bit that blocks nested exceptions. It sits beside the control unit and tells the PC mux when to redirect to the exception vector or return to EPC.

Parameters:
NUM_IRQ, 4, number of external interrupt lines; legal range 1..7.
IRQ_EDGE, 0, NUM_IRQ-bit mask; bit i=1 makes line i edge-triggered, 0 makes it level-triggered.
TIMER_EN, 1, 1 enables Count/Compare and the timer interrupt; 0 makes Count/Compare read 0 and ignore writes.
EXC_VECTOR, 32'h0000_0008, PC loaded when an exception is taken.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
irq  in  NUM_IRQ  external interrupt requests; asynchronous to clk.
inst_valid  in  1  the current instruction is valid.
pc  in  32  address of the current instruction.
exc_sys  in  1  current instruction is syscall.
exc_uni  in  1  current instruction is unimplemented.
exc_ovr  in  1  current add/sub/addi overflowed.
mtc0  in  1  move-to-CP0.
mfc0  in  1  move-from-CP0.
eret  in  1  return from exception.
rd  in  5  CP0 register number.
wdata  in  32  mtc0 write data.
rdata  out  32  mfc0 read data.
exc_req  out  1  exception taken this cycle; the current instruction must be squashed.
selpc  out  2  PC select: 00 = pc+4/branch, 01 = EPC, 10 = EXC_VECTOR.
epc_out  out  32  current EPC.
irq_ack  out  NUM_IRQ+1  one-hot; marks the interrupt source taken this cycle (bit NUM_IRQ = timer).

Behaviour:
- Register map (rd):
  - 9 Count.
  - 11 Compare.
  - 12 Status: [0] IE, [1] SE syscall enable, [2] UE unimplemented enable, [3] OE overflow enable, [4] EXL, [8+NUM_IRQ:8] IM. Other bits read 0.
  - 13 Cause: [6:2] ExcCode, [8+NUM_IRQ:8] IP (read-only). Other bits 0.
  - 14 EPC.
  - Any other rd reads 0 and ignores writes.
- Reset (asynchronous) values:
  - Status=0, Cause=0, EPC=0, Count=0, Compare=32'hFFFF_FFFF.
  - All synchroniser and pending flops 0.
  - Resulting outputs: exc_req=0, selpc=00, irq_ack=0, rdata=0.
  - Reset mid-operation discards all pending interrupts.
- Synchronisation and pending:
  - Each irq line passes through a 2-flop synchroniser (s2), followed by a delay flop s3.
  - Level line: IP[i]=s2[i]. IP rises 2 cycles after irq rises and falls when irq falls, with the same 2-cycle lag.
  - Edge line: s2&~s3 sets a sticky pending flop. IP rises 3 cycles after the irq edge. The flop clears only when that line is taken (irq_ack[i]).
- Timer (TIMER_EN=1):
  - Count increments every cycle and wraps 32'hFFFF_FFFF to 0.
  - When Count==Compare, the timer-pending flop sets on the next edge; it is IP[NUM_IRQ] and is sticky.
  - An mtc0 write to Compare clears timer-pending.
  - An mtc0 write to Count loads wdata in place of incrementing.
- Take condition (combinational):
  - int_take = IE & |(IP & IM).
  - exc_req = inst_valid & ~EXL & (int_take | exc_ovr&OE | exc_uni&UE | exc_sys&SE).
- Priority:
  - Interrupt is highest, then ovr, then uni, then sys.
  - Among interrupts, the highest IP index wins, so the timer has top priority.
  - irq_ack is asserted combinationally for the winning source only when int_take wins.
- On a taken exception, at the clock edge:
  - EXL<=1.
  - ExcCode<=0 (interrupt), 12 (ovr), 10 (uni), or 8 (sys).
  - EPC<=pc+4 for syscall; EPC<=pc for all others.
  - The acked edge/timer pending flop clears.
  - Same cycle: selpc=10.
- mtc0 and eret on an exc_req cycle are suppressed (the instruction is squashed).
- eret without exc_req: EXL<=0, selpc=01. With EXL=0 this is harmless.
- mtc0 write:
  - Takes effect at the next edge and is visible to mfc0 the following cycle.
  - A Status write can set or clear EXL.
  - IP bits are not writable; a Cause write updates ExcCode only.
- mfc0: rdata is combinational from current register values; rdata=0 when mfc0=0.
- While EXL=1, pending requests stay latched and are taken on the first valid instruction after EXL clears, provided IE and IM permit.

Test Plan:
- Reset with irq=all-1 → exc_req=0, selpc=00, Compare=FFFF_FFFF, Status=0.
- Level line 0, Status=0x101, pc=0x40 → IP[0]=1 two cycles after irq; exc_req=1, EPC=0x40, ExcCode=0, EXL=1, irq_ack=0b00001.
- Edge line 2 (IRQ_EDGE=4'b0100) pulsed for 1 cycle, then IE set 10 cycles later → pending held, taken once, IP[2] clears after ack; eret → selpc=01, PC=EPC, EXL=0.
- Compare=5, Count=0, IM timer bit and IE set → exception with irq_ack[NUM_IRQ]=1 about 6 cycles later; mtc0 Compare clears IP[NUM_IRQ].
- Syscall with SE=1 at pc=0x100 while line 1 is pending and IE=1 → interrupt wins (ExcCode 0, EPC=0x100); after eret, syscall → ExcCode 8, EPC=0x104.
- EXL=1 with overflow, OE=1 and irq pending → exc_req=0; mtc0 with rd=13 changes only ExcCode; a read of rd=7 returns 0.
